// File: rtl/barrel_shift_pkg.sv
// barrel_shift_pkg: shared mode encoding and id-width helper for the shift arbiter
package barrel_shift_pkg;
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_SHL = 2'b00;
  localparam mode_t MODE_SHR = 2'b01;
  localparam mode_t MODE_ROL = 2'b10;
  localparam mode_t MODE_ROR = 2'b11;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/barrel_shifter.sv
// barrel_shifter: combinational N-bit shift/rotate unit
module barrel_shifter
  import barrel_shift_pkg::*;
#(
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  data,
  input  logic [SW-1:0] shift,
  input  mode_t         mode,
  output logic [N-1:0]  res
);
  logic [2*N-1:0] dl, dr;
  // rotations fall out of shifting the operand concatenated with itself
  always_comb begin
    dl = {data, data} << shift;
    dr = {data, data} >> shift;
    res = (mode == MODE_SHL) ? data << shift :
          (mode == MODE_SHR) ? data >> shift :
          (mode == MODE_ROL) ? dl[2*N-1:N] : dr[N-1:0];
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant scanning upward from ptr with wraparound
module rr_arbiter
  import barrel_shift_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);
  logic [IW-1:0] j;
  // scan from farthest to nearest so the nearest hit after ptr wins
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % NREQ);
      if (en && req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter: round-robin sharing of one barrel shifter with a registered tagged response
module barrel_shift_arbiter
  import barrel_shift_pkg::*;
#(
  parameter int N = 4,
  parameter int NREQ = 4,
  localparam int SW = $clog2(N),
  localparam int IW = id_w(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*N-1:0]  req_data,
  input  logic [NREQ*SW-1:0] req_shift,
  input  logic [NREQ*2-1:0]  req_mode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_data,
  output logic [IW-1:0]    rsp_id
);
  logic [IW-1:0] ptr, idx;
  logic [NREQ-1:0] grant;
  logic [N-1:0] sel_data, shifted;
  logic [SW-1:0] sel_shift;
  mode_t sel_mode;
  logic cap;
  assign cap = !rsp_valid || rsp_ready;
  assign req_ready = grant;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(req_valid), .ptr(ptr), .en(rst_n && cap), .grant(grant), .idx(idx)
  );
  always_comb begin
    sel_data = req_data[int'(idx)*N +: N];
    sel_shift = req_shift[int'(idx)*SW +: SW];
    sel_mode = req_mode[int'(idx)*2 +: 2];
  end
  barrel_shifter #(.N(N)) u_shf (
    .data(sel_data), .shift(sel_shift), .mode(sel_mode), .res(shifted)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_id <= '0;
      ptr <= '0;
    end else if (|grant) begin
      rsp_valid <= 1'b1;
      rsp_data <= shifted;
      rsp_id <= idx;
      ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// tb_barrel_shift_arbiter: table, directed and randomized checks against a cycle-level reference model
module tb_barrel_shift_arbiter;
  localparam int N = 4;
  localparam int NREQ = 4;
  localparam int SW = 2;
  localparam int IW = 2;
  logic clk = 0;
  logic rst_n;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ*SW-1:0] req_shift;
  logic [NREQ*2-1:0] req_mode;
  logic rsp_valid, rsp_ready;
  logic [N-1:0] rsp_data;
  logic [IW-1:0] rsp_id;
  int n_chk = 0, n_fail = 0;
  int m_valid, m_data, m_id, m_ptr, last_g;
  barrel_shift_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_shift(req_shift), .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
  );
  always #5 clk = ~clk;
  typedef struct {int mode; int shift; int data; int exp;} vec_t;
  vec_t vecs[8];
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // arithmetic definition of the four shift modes
  function automatic int shf(input int d, input int s, input int m);
    int p;
    p = 2 ** N;
    case (m)
      0: return (d * (2 ** s)) % p;
      1: return d / (2 ** s);
      2: return (d * (2 ** s)) % p + d / (2 ** (N - s));
      default: return d / (2 ** s) + (d * (2 ** (N - s))) % p;
    endcase
  endfunction
  function automatic int model_grant();
    if (!rst_n || (m_valid && !rsp_ready)) return -1;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction
  task automatic cycle();
    int g;
    #1;
    g = model_grant();
    chk("req_ready", req_ready, g < 0 ? 0 : (1 << g));
    chk("rsp_valid", rsp_valid, m_valid);
    chk("rsp_data", rsp_data, m_data);
    chk("rsp_id", rsp_id, m_id);
    @(posedge clk);
    #1;
    last_g = g;
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0;
    end else if (g >= 0) begin
      m_data = shf(req_data[g*N +: N], req_shift[g*SW +: SW], req_mode[g*2 +: 2]);
      m_id = g; m_valid = 1; m_ptr = (g + 1) % NREQ;
    end else if (rsp_ready) m_valid = 0;
  endtask
  task automatic set_all(input int d, input int s, input int m);
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*N +: N] = N'(d);
      req_shift[i*SW +: SW] = SW'(s);
      req_mode[i*2 +: 2] = 2'(m);
    end
  endtask
  task automatic do_reset();
    rst_n = 0;
    cycle();
    rst_n = 1;
  endtask
  initial begin
    int seq[6] = '{0, 1, 2, 3, 0, 1};
    int sp[3] = '{1, 3, 1};
    vecs = '{'{0, 2, 11, 12}, '{1, 1, 11, 5}, '{2, 1, 11, 7}, '{3, 1, 11, 13},
             '{0, 0, 11, 11}, '{1, 0, 11, 11}, '{2, 0, 11, 11}, '{3, 0, 11, 11}};
    rst_n = 0; req_valid = '1; rsp_ready = 1; set_all(0, 0, 0);
    @(posedge clk); #1;
    m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0;
    chk("reset_rdy", req_ready, 0);
    chk("reset_valid", rsp_valid, 0);
    chk("reset_data", rsp_data, 0);
    chk("reset_id", rsp_id, 0);
    rst_n = 1; req_valid = 4'b0001;
    foreach (vecs[i]) begin
      req_data[0 +: N] = N'(vecs[i].data);
      req_shift[0 +: SW] = SW'(vecs[i].shift);
      req_mode[0 +: 2] = 2'(vecs[i].mode);
      #1 chk("mode_rdy", req_ready, 1);
      cycle();
      chk("mode_valid", rsp_valid, 1);
      chk("mode_data", rsp_data, vecs[i].exp);
      chk("mode_id", rsp_id, 0);
    end
    req_valid = 0;
    cycle();
    // fairness from a fresh pointer
    do_reset();
    set_all(6, 0, 0);
    req_valid = 4'b1111;
    foreach (seq[i]) begin
      cycle();
      chk("fair_id", rsp_id, seq[i]);
      chk("fair_valid", rsp_valid, 1);
    end
    cycle();
    chk("bp_id", rsp_id, 2);
    chk("bp_data", rsp_data, 6);
    rsp_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_rdy", req_ready, 0);
      cycle();
      chk("bp_hold_id", rsp_id, 2);
      chk("bp_hold_data", rsp_data, 6);
      chk("bp_hold_valid", rsp_valid, 1);
    end
    rsp_ready = 1;
    #1 chk("bp_release_rdy", req_ready, 8);
    cycle();
    chk("bp_next_id", rsp_id, 3);
    req_valid = 4'b1010;
    foreach (sp[i]) begin
      cycle();
      chk("sparse_id", rsp_id, sp[i]);
    end
    rsp_ready = 0; rst_n = 0; req_valid = 4'b0110;
    #1 chk("rst_rdy", req_ready, 0);
    cycle();
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_id", rsp_id, 0);
    rst_n = 1; rsp_ready = 1;
    cycle();
    chk("post_rst_id", rsp_id, 1);
    req_valid = 0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("idle_valid", rsp_valid, 0);
      chk("idle_rdy", req_ready, 0);
    end
    req_valid = 4'b1111;
    cycle();
    chk("idle_ptr_id", rsp_id, 2);
    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom);
      req_data = ($urandom);
      req_shift = ($urandom);
      req_mode = ($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      rst_n = ($urandom_range(0, 49) != 0);
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
